seg_display_ctrl: RTL and testbench
===================================

Name: seg_display_ctrl

Overview:
- Sequential controller that converts a binary count (e.g. RPM) into four seven-segment digit patterns.
- Drives the seg_a..seg_d inputs of the 4-digit display multiplexer.
- Converts with an iterative shift-add-3 (double-dabble) loop, one bit per clock. Applies leading-zero blanking and an overflow indication.
- Accepts new values over a valid/ready handshake. Holds the last displayed value between updates.

Parameters:
- IN_W, 14, binary input width. Max displayable value is 9999.
- BLANK_LEADING, 1, when 1, leading zero digits are blanked (ones digit is never blanked).
- SEG_ACTIVE_LOW, 0, when 1, all four seg outputs are bitwise inverted. Reset/blank value becomes 8'hFF.

Ports:
- clk  input  1  system clock (50 MHz)
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_value/in_dp are valid this cycle
- in_ready  output  1  controller can accept a value (high only in IDLE)
- in_value  input  IN_W  unsigned binary value to display
- in_dp  input  4  decimal-point enables; bit0 = ones digit … bit3 = thousands digit
- seg_a  output  8  ones digit pattern (registered)
- seg_b  output  8  tens digit pattern (registered)
- seg_c  output  8  hundreds digit pattern (registered)
- seg_d  output  8  thousands digit pattern (registered)
- busy  output  1  conversion in progress (state != IDLE)
- update  output  1  one-cycle pulse on the cycle the seg outputs change

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, sampled on the rising edge of clk.
- Segment encoding, active-high before polarity: bit0=a … bit6=g, bit7=dp.
  - Digits 0–9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F.
  - Dash = 40. Blank = 00.
- Reset: state=IDLE; seg_a..seg_d=blank (00, or FF if SEG_ACTIVE_LOW); update=0; busy=0. All internal shift/BCD/count registers are cleared.
- in_ready is combinational, equal to (state==IDLE). It is therefore high in the first cycle after reset deasserts.
- States:
  - IDLE:
    - On in_valid & in_ready at edge T: capture in_value into the shift register and in_dp into dp_reg.
    - Set ovf = (in_value > 9999). Clear the 16-bit BCD accumulator and the iteration counter. Go to CONV.
    - If in_valid is low, hold.
  - CONV:
    - Each edge: every BCD nibble >= 5 gets +3. Then {bcd, shift} shifts left by 1.
    - Counter increments. After IN_W iterations (edges T+1..T+IN_W), go to LOAD.
  - LOAD (edge T+IN_W+1):
    - Encode nibbles and write seg_a..seg_d. Pulse update=1 for this cycle. Return to IDLE.
- Latency: the new pattern is visible IN_W+1 cycles after the accepting edge (15 for default). The next value can be accepted at edge T+IN_W+2.
- Inputs while busy: in_valid is ignored while in_ready=0. Senders must hold in_valid until the handshake; no input is queued.
- Blanking (BLANK_LEADING=1):
  - Digit d is blanked if it and all higher digits are 0.
  - seg_a always shows a numeral, so value 0 displays "0".
  - With BLANK_LEADING=0, all four digits show numerals.
- Decimal points:
  - dp_reg[i] ORs into bit7 of digit i, including blanked digits.
  - A dp on a blanked digit forces that digit to display its numeral "0" (e.g. in_dp=0100, value 5 shows "0.05").
- Overflow:
  - If ovf, LOAD writes dash (40) to all four digits, with dp bits cleared.
  - The conversion still runs, so latency is identical.
- Polarity: SEG_ACTIVE_LOW inversion is applied to the final registered value, including the reset value.
- Reset mid-operation: rst in CONV or LOAD aborts. Seg outputs blank, update=0, state=IDLE. No partial value is ever written to the seg outputs.
- Seg outputs change only on a LOAD edge or on reset.

Test Plan:
- Reset, then in_valid=1 with in_value=1234, in_dp=0 -> in_ready low for 15 cycles. update pulses at edge T+15 with seg_d..seg_a = 06,5B,4F,66. in_ready high at T+16.
- in_value=7 with BLANK_LEADING=1 -> seg_d..seg_a = 00,00,00,07. in_value=0 -> 00,00,00,3F. Same two values with BLANK_LEADING=0 -> 3F,3F,3F,07 and 3F,3F,3F,3F.
- in_value=5, in_dp=4'b0100 -> seg_c=BF, seg_b=3F, seg_a=6D, seg_d=00.
- in_value=10000 -> all four digits = 40, update at T+15. in_value=9999 -> all four = 6F.
- Assert in_valid with value 42 while busy converting 1234 -> 42 is not accepted until in_ready=1. The 1234 result appears first, then 42 (00,00,66,5B) 15 cycles after its handshake.
- Assert rst at T+8 during conversion of 8888 -> seg outputs stay 00 and update never pulses. With SEG_ACTIVE_LOW=1, outputs read FF after reset and 8888 displays 80 on all digits.

Source files
------------

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: iterative double-dabble binary to four seven-segment digit patterns with blanking, dp and overflow
module seg_display_ctrl #(
  parameter int IN_W = 14,
  parameter int BLANK_LEADING = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_value,
  input  logic [3:0]      in_dp,
  output logic [7:0]      seg_a,
  output logic [7:0]      seg_b,
  output logic [7:0]      seg_c,
  output logic [7:0]      seg_d,
  output logic            busy,
  output logic            update
);
  localparam int CW = $clog2(IN_W + 1);
  localparam logic [7:0] POL = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  state_t          r_state;
  logic [IN_W-1:0] r_shift;
  logic [15:0]     r_bcd;
  logic [15:0]     w_adj;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_dp;
  logic [3:0]      w_zero;
  logic [3:0]      w_blank;
  logic            r_ovf;
  logic            r_update;
  logic [7:0]      r_seg [4];
  logic [7:0]      w_pat [4];
  function automatic logic [6:0] f_seg(input logic [3:0] n);
    case (n)
      4'd0: f_seg = 7'h3F;
      4'd1: f_seg = 7'h06;
      4'd2: f_seg = 7'h5B;
      4'd3: f_seg = 7'h4F;
      4'd4: f_seg = 7'h66;
      4'd5: f_seg = 7'h6D;
      4'd6: f_seg = 7'h7D;
      4'd7: f_seg = 7'h07;
      4'd8: f_seg = 7'h7F;
      4'd9: f_seg = 7'h6F;
      default: f_seg = 7'h00;
    endcase
  endfunction
  for (genvar i = 0; i < 4; i++) begin : g_dig
    assign w_adj[4*i+:4] = (r_bcd[4*i+:4] >= 4'd5) ? r_bcd[4*i+:4] + 4'd3 : r_bcd[4*i+:4];
    assign w_zero[i] = (r_bcd[4*i+:4] == 4'd0) && !r_dp[i];
    assign w_pat[i] = r_ovf ? 8'h40 : {r_dp[i], w_blank[i] ? 7'h00 : f_seg(r_bcd[4*i+:4])};
  end
  assign w_blank = (BLANK_LEADING != 0) ? {w_zero[3], &w_zero[3:2], &w_zero[3:1], 1'b0} : 4'b0;
  assign in_ready = r_state == IDLE;
  assign busy = r_state != IDLE;
  assign update = r_update;
  assign seg_a = r_seg[0];
  assign seg_b = r_seg[1];
  assign seg_c = r_seg[2];
  assign seg_d = r_seg[3];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_dp <= '0;
      r_ovf <= 1'b0;
      r_update <= 1'b0;
      r_seg <= '{default: POL};
    end else begin
      r_update <= 1'b0;
      case (r_state)
        IDLE: if (in_valid) begin
          r_shift <= in_value;
          r_dp <= in_dp;
          r_ovf <= 32'(in_value) > 32'd9999;
          r_bcd <= '0;
          r_cnt <= '0;
          r_state <= CONV;
        end
        CONV: begin
          {r_bcd, r_shift} <= {w_adj[14:0], r_shift, 1'b0};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(IN_W - 1)) r_state <= LOAD;
        end
        LOAD: begin
          for (int i = 0; i < 4; i++) r_seg[i] <= w_pat[i] ^ POL;
          r_update <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: directed self-checking bench for seg_display_ctrl
module tb_seg_display_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [13:0] in_value = '0;
  logic [3:0]  in_dp = '0;
  logic        d_ready, d_busy, d_upd, n_ready, n_busy, n_upd, a_ready, a_busy, a_upd;
  logic [7:0]  d_a, d_b, d_c, d_d, n_a, n_b, n_c, n_d, a_a, a_b, a_c, a_d;
  int          n_checks = 0;
  int          n_fail = 0;
  always #10 clk = ~clk;
  seg_display_ctrl #(.IN_W(14), .BLANK_LEADING(1), .SEG_ACTIVE_LOW(0)) u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_ready), .in_value(in_value), .in_dp(in_dp),
    .seg_a(d_a), .seg_b(d_b), .seg_c(d_c), .seg_d(d_d), .busy(d_busy), .update(d_upd));
  seg_display_ctrl #(.IN_W(14), .BLANK_LEADING(0), .SEG_ACTIVE_LOW(0)) u_nb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_ready), .in_value(in_value), .in_dp(in_dp),
    .seg_a(n_a), .seg_b(n_b), .seg_c(n_c), .seg_d(n_d), .busy(n_busy), .update(n_upd));
  seg_display_ctrl #(.IN_W(14), .BLANK_LEADING(1), .SEG_ACTIVE_LOW(1)) u_al (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ready), .in_value(in_value), .in_dp(in_dp),
    .seg_a(a_a), .seg_b(a_b), .seg_c(a_c), .seg_d(a_d), .busy(a_busy), .update(a_upd));
  task automatic run_conv(input logic [13:0] v, input logic [3:0] dp, output int lat, output int ready_low);
    in_value = v;
    in_dp = dp;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = -1;
    ready_low = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (d_upd) begin
        lat = i;
        break;
      end
      if (!d_ready) ready_low++;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({d_d, d_c, d_b, d_a} !== 32'h0) begin n_fail++; $display("FAIL reset_seg_def got=%h exp=00000000", {d_d, d_c, d_b, d_a}); end
    n_checks++;
    if ({a_d, a_c, a_b, a_a} !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL reset_seg_al got=%h exp=ffffffff", {a_d, a_c, a_b, a_a}); end
    n_checks++;
    if ({d_upd, d_busy, a_upd, a_busy} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", {d_upd, d_busy, a_upd, a_busy}); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (d_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", d_ready); end
  endtask
  task automatic test_basic;
    int lat, rl;
    run_conv(14'd1234, 4'b0000, lat, rl);
    n_checks++;
    if (lat !== 15) begin n_fail++; $display("FAIL basic_latency got=%0d exp=15", lat); end
    n_checks++;
    if (rl !== 14) begin n_fail++; $display("FAIL basic_ready_low got=%0d exp=14", rl); end
    n_checks++;
    if ({d_d, d_c, d_b, d_a} !== 32'h065B4F66) begin n_fail++; $display("FAIL basic_seg got=%h exp=065b4f66", {d_d, d_c, d_b, d_a}); end
    n_checks++;
    if ({a_d, a_c, a_b, a_a} !== 32'hF9A4B099) begin n_fail++; $display("FAIL basic_seg_al got=%h exp=f9a4b099", {a_d, a_c, a_b, a_a}); end
    n_checks++;
    if ({d_ready, d_busy, n_upd, a_upd} !== 4'b1011) begin n_fail++; $display("FAIL basic_flags got=%b exp=1011", {d_ready, d_busy, n_upd, a_upd}); end
    @(posedge clk);
    #1;
    n_checks++;
    if ({d_upd, d_d, d_c, d_b, d_a} !== {1'b0, 32'h065B4F66}) begin n_fail++; $display("FAIL basic_hold got=%h exp=0065b4f66", {d_upd, d_d, d_c, d_b, d_a}); end
  endtask
  task automatic test_blanking;
    int lat, rl;
    run_conv(14'd7, 4'b0000, lat, rl);
    n_checks++;
    if ({d_d, d_c, d_b, d_a} !== 32'h00000007) begin n_fail++; $display("FAIL blank7_def got=%h exp=00000007", {d_d, d_c, d_b, d_a}); end
    n_checks++;
    if ({n_d, n_c, n_b, n_a} !== 32'h3F3F3F07) begin n_fail++; $display("FAIL blank7_nb got=%h exp=3f3f3f07", {n_d, n_c, n_b, n_a}); end
    run_conv(14'd0, 4'b0000, lat, rl);
    n_checks++;
    if ({d_d, d_c, d_b, d_a} !== 32'h0000003F) begin n_fail++; $display("FAIL blank0_def got=%h exp=0000003f", {d_d, d_c, d_b, d_a}); end
    n_checks++;
    if ({n_d, n_c, n_b, n_a} !== 32'h3F3F3F3F) begin n_fail++; $display("FAIL blank0_nb got=%h exp=3f3f3f3f", {n_d, n_c, n_b, n_a}); end
  endtask
  task automatic test_dp;
    int lat, rl;
    run_conv(14'd5, 4'b0100, lat, rl);
    n_checks++;
    if ({d_d, d_c, d_b, d_a} !== 32'h00BF3F6D) begin n_fail++; $display("FAIL dp_def got=%h exp=00bf3f6d", {d_d, d_c, d_b, d_a}); end
    n_checks++;
    if ({n_d, n_c, n_b, n_a} !== 32'h3FBF3F6D) begin n_fail++; $display("FAIL dp_nb got=%h exp=3fbf3f6d", {n_d, n_c, n_b, n_a}); end
    n_checks++;
    if ({a_d, a_c, a_b, a_a} !== 32'hFF40C092) begin n_fail++; $display("FAIL dp_al got=%h exp=ff40c092", {a_d, a_c, a_b, a_a}); end
  endtask
  task automatic test_overflow;
    int lat, rl;
    run_conv(14'd10000, 4'b1111, lat, rl);
    n_checks++;
    if (lat !== 15) begin n_fail++; $display("FAIL ovf_latency got=%0d exp=15", lat); end
    n_checks++;
    if ({d_d, d_c, d_b, d_a} !== 32'h40404040) begin n_fail++; $display("FAIL ovf_def got=%h exp=40404040", {d_d, d_c, d_b, d_a}); end
    n_checks++;
    if ({a_d, a_c, a_b, a_a} !== 32'hBFBFBFBF) begin n_fail++; $display("FAIL ovf_al got=%h exp=bfbfbfbf", {a_d, a_c, a_b, a_a}); end
    run_conv(14'd9999, 4'b0000, lat, rl);
    n_checks++;
    if ({d_d, d_c, d_b, d_a} !== 32'h6F6F6F6F) begin n_fail++; $display("FAIL max_def got=%h exp=6f6f6f6f", {d_d, d_c, d_b, d_a}); end
    n_checks++;
    if ({a_d, a_c, a_b, a_a} !== 32'h90909090) begin n_fail++; $display("FAIL max_al got=%h exp=90909090", {a_d, a_c, a_b, a_a}); end
  endtask
  task automatic test_back_to_back;
    int lat;
    in_value = 14'd1234;
    in_dp = 4'b0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_value = 14'd42;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (d_upd) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if (lat !== 15) begin n_fail++; $display("FAIL b2b_first_latency got=%0d exp=15", lat); end
    n_checks++;
    if ({d_d, d_c, d_b, d_a} !== 32'h065B4F66) begin n_fail++; $display("FAIL b2b_first_seg got=%h exp=065b4f66", {d_d, d_c, d_b, d_a}); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (d_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got=%b exp=1", d_busy); end
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (d_upd) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if (lat !== 15) begin n_fail++; $display("FAIL b2b_second_latency got=%0d exp=15", lat); end
    n_checks++;
    if ({d_d, d_c, d_b, d_a} !== 32'h0000665B) begin n_fail++; $display("FAIL b2b_second_seg got=%h exp=0000665b", {d_d, d_c, d_b, d_a}); end
    n_checks++;
    if ({n_d, n_c, n_b, n_a} !== 32'h3F3F665B) begin n_fail++; $display("FAIL b2b_second_nb got=%h exp=3f3f665b", {n_d, n_c, n_b, n_a}); end
  endtask
  task automatic test_reset_mid;
    int upd_seen, lat, rl;
    in_value = 14'd8888;
    in_dp = 4'b0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    n_checks++;
    if (d_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got=%b exp=1", d_busy); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    upd_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (d_upd || a_upd) upd_seen++;
    end
    n_checks++;
    if (upd_seen !== 0) begin n_fail++; $display("FAIL mid_update got=%0d exp=0", upd_seen); end
    n_checks++;
    if ({d_d, d_c, d_b, d_a} !== 32'h0) begin n_fail++; $display("FAIL mid_seg_def got=%h exp=00000000", {d_d, d_c, d_b, d_a}); end
    n_checks++;
    if ({a_d, a_c, a_b, a_a} !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mid_seg_al got=%h exp=ffffffff", {a_d, a_c, a_b, a_a}); end
    n_checks++;
    if ({d_busy, d_ready} !== 2'b01) begin n_fail++; $display("FAIL mid_state got=%b exp=01", {d_busy, d_ready}); end
    run_conv(14'd8888, 4'b0000, lat, rl);
    n_checks++;
    if (lat !== 15) begin n_fail++; $display("FAIL rerun_latency got=%0d exp=15", lat); end
    n_checks++;
    if ({d_d, d_c, d_b, d_a} !== 32'h7F7F7F7F) begin n_fail++; $display("FAIL rerun_def got=%h exp=7f7f7f7f", {d_d, d_c, d_b, d_a}); end
    n_checks++;
    if ({a_d, a_c, a_b, a_a} !== 32'h80808080) begin n_fail++; $display("FAIL rerun_al got=%h exp=80808080", {a_d, a_c, a_b, a_a}); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_blanking;
    test_dp;
    test_overflow;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
